// File: rtl/alu_pkg.sv
// alu_pkg: constants shared between the operand stage and the ALU.
//   - Datapath, register-file, opcode, flag and immediate widths.
//   - PSR flag bit positions, ordered {C,L,F,Z,N} from bit4 down to bit0.
//   - Opcode encodings the ALU decodes. The operand stage passes opcodes
//     through untouched.
package alu_pkg;

    localparam int BIT_WIDTH    = 16;
    localparam int REG_COUNT    = 16;
    localparam int OPCODE_WIDTH = 8;
    localparam int FLAG_WIDTH   = 5;
    localparam int IMM_WIDTH    = 8;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 8'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 8'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDU = 8'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 8'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP  = 8'h0B;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = 8'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_LSH  = 8'h84;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register array with two asynchronous read ports and one
// synchronous write port.
//   clk, reset          rising-edge clock, synchronous active-high clear
//   we, waddr, wdata    write port. A write in a reset cycle is dropped.
//   raddr_a / rdata_a   read port A (combinational)
//   raddr_b / rdata_b   read port B (combinational)
// A read of the address being written in the same cycle returns the old
// value. Forwarding, if wanted, is done by the instantiating stage.
module regfile_2r1w #(
    parameter int BIT_WIDTH = alu_pkg::BIT_WIDTH,
    parameter int REG_COUNT = alu_pkg::REG_COUNT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(REG_COUNT)-1:0] waddr,
    input  logic [BIT_WIDTH-1:0]         wdata,
    input  logic [$clog2(REG_COUNT)-1:0] raddr_a,
    output logic [BIT_WIDTH-1:0]         rdata_a,
    input  logic [$clog2(REG_COUNT)-1:0] raddr_b,
    output logic [BIT_WIDTH-1:0]         rdata_b
);
    import alu_pkg::*;

    logic [REG_COUNT-1:0][BIT_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch/issue stage in front of the ALU, with the PSR.
//   id_*   decoder side. Register addresses, raw immediate and its select and
//          extension controls, and a valid/ready handshake.
//   ex_*   one-deep registered slot feeding the ALU: opcode, Rdest,
//          Rsrc_Imm and destination address, with a valid/ready handshake.
//   wb_*   ALU result writeback into the register file.
//   flags_in / flags_we / psr
//          ALU flags merged into the PSR under a per-bit mask.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a
// same-cycle writeback to an address being read is forwarded into the
// accepted operand. When it is not defined, the read returns the pre-write
// value.
module alu_operand_stage #(
    parameter int BIT_WIDTH    = alu_pkg::BIT_WIDTH,
    parameter int REG_COUNT    = alu_pkg::REG_COUNT,
    parameter int OPCODE_WIDTH = alu_pkg::OPCODE_WIDTH,
    parameter int FLAG_WIDTH   = alu_pkg::FLAG_WIDTH,
    parameter int IMM_WIDTH    = alu_pkg::IMM_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    output logic                         id_ready,
    input  logic [OPCODE_WIDTH-1:0]      id_opcode,
    input  logic [$clog2(REG_COUNT)-1:0] id_rdest_addr,
    input  logic [$clog2(REG_COUNT)-1:0] id_rsrc_addr,
    input  logic [IMM_WIDTH-1:0]         id_imm,
    input  logic                         id_use_imm,
    input  logic                         id_imm_signed,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [OPCODE_WIDTH-1:0]      ex_opcode,
    output logic [BIT_WIDTH-1:0]         ex_rdest,
    output logic [BIT_WIDTH-1:0]         ex_rsrc_imm,
    output logic [$clog2(REG_COUNT)-1:0] ex_dest_addr,
    input  logic                         wb_en,
    input  logic [$clog2(REG_COUNT)-1:0] wb_addr,
    input  logic [BIT_WIDTH-1:0]         wb_data,
    input  logic [FLAG_WIDTH-1:0]        flags_in,
    input  logic [FLAG_WIDTH-1:0]        flags_we,
    output logic [FLAG_WIDTH-1:0]        psr
);
    import alu_pkg::*;

    logic                 accept;
    logic [BIT_WIDTH-1:0] rdest_rd, rsrc_rd;
    logic [BIT_WIDTH-1:0] rdest_op, rsrc_op;
    logic [BIT_WIDTH-1:0] imm_ext, rsrc_imm;

    regfile_2r1w #(.BIT_WIDTH(BIT_WIDTH), .REG_COUNT(REG_COUNT)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (id_rdest_addr),
        .rdata_a (rdest_rd),
        .raddr_b (id_rsrc_addr),
        .rdata_b (rsrc_rd)
    );

    // The slot can take a new instruction when it is empty or is being
    // drained this cycle. id_valid is deliberately not part of this term.
    assign id_ready = !ex_valid || ex_ready;
    assign accept   = id_valid && id_ready;

`ifdef REGFILE_BYPASS_EN
    assign rdest_op = (wb_en && wb_addr == id_rdest_addr) ? wb_data : rdest_rd;
    assign rsrc_op  = (wb_en && wb_addr == id_rsrc_addr)  ? wb_data : rsrc_rd;
`else
    assign rdest_op = rdest_rd;
    assign rsrc_op  = rsrc_rd;
`endif

    assign imm_ext  = id_imm_signed
                    ? {{(BIT_WIDTH-IMM_WIDTH){id_imm[IMM_WIDTH-1]}}, id_imm}
                    : {{(BIT_WIDTH-IMM_WIDTH){1'b0}}, id_imm};
    assign rsrc_imm = id_use_imm ? imm_ext : rsrc_op;

    // Slot register. While valid and not drained, every ex_* field holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_rdest     <= '0;
            ex_rsrc_imm  <= '0;
            ex_dest_addr <= '0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_opcode    <= id_opcode;
            ex_rdest     <= rdest_op;
            ex_rsrc_imm  <= rsrc_imm;
            ex_dest_addr <= id_rdest_addr;
        end else if (ex_ready) begin
            ex_valid     <= 1'b0;
        end
    end

    // Each PSR bit is updated only under its own mask bit. The ALU may drive
    // x on flags it does not define, so a masked-off bit must never read
    // flags_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            psr <= '0;
        end else begin
            for (int i = 0; i < FLAG_WIDTH; i++) begin
                if (flags_we[i]) psr[i] <= flags_in[i];
            end
        end
    end

endmodule
